mem_port_arbiter: RTL and testbench

Shares the single unified memory port between the instruction-fetch requester (IF, read-only) and the data requester (DM, ld/sd read/write) of the multicycle core. It serialises accesses, performs one access at a time, and sequences issue, latency wait and response. Data has priority over fetch, with a streak limit that bounds fetch starvation. It sits between the control FSM / IR / data register and the memory macro.

---
 rtl/mem_arb_pkg.sv | 16 +
 rtl/mem_arb_pick.sv | 26 ++
 rtl/mem_port_arbiter.sv | 125 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the unified memory-port arbiter.
//   state_t  : arbiter FSM states
//   owner_t  : which requester owns the in-flight access
//   streak_w : width of the DM streak counter for a given streak limit
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  typedef enum logic {OWN_IF, OWN_DM} owner_t;

  // Must hold values 0..max_streak inclusive.
  function automatic int streak_w(input int max_streak);
    return $clog2(max_streak + 1);
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant picker.
//   if_req, dm_req : pending requests (valid only while the arbiter is idle)
//   streak         : consecutive DM grants taken while fetch was waiting
//   gnt_vld        : some request can be granted
//   owner          : winner; DM unless fetch has waited MAX_DM_STREAK grants
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int MAX_DM_STREAK = 4,
  parameter int SW            = streak_w(MAX_DM_STREAK)
) (
  input  logic          if_req,
  input  logic          dm_req,
  input  logic [SW-1:0] streak,
  output logic          gnt_vld,
  output owner_t        owner
);

  logic at_limit;

  assign at_limit = (streak == SW'(MAX_DM_STREAK));
  assign gnt_vld  = if_req | dm_req;
  // Fetch only wins a contested cycle once the streak has saturated.
  assign owner    = (dm_req && !(if_req && at_limit)) ? OWN_DM : OWN_IF;

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises instruction-fetch (read-only) and data (ld/sd) accesses onto one
// memory port. One access in flight at a time: IDLE -> ISSUE -> [WAIT] -> RESP.
//   IF_*      : fetch requester (REQ held until GNT; RVALID/RDATA response)
//   DM_*      : data requester (WE selects sd; RVALID for ld, WDONE for sd)
//   MEM_*     : memory macro port; MEM_RDATA valid MEM_LAT cycles after issue
//   BUSY      : arbiter is not idle
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 64,
  parameter int MEM_LAT       = 1,
  parameter int MAX_DM_STREAK = 4
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              IF_REQ,
  input  logic [ADDR_W-1:0] IF_ADDR,
  output logic              IF_GNT,
  output logic              IF_RVALID,
  output logic [DATA_W-1:0] IF_RDATA,
  input  logic              DM_REQ,
  input  logic              DM_WE,
  input  logic [ADDR_W-1:0] DM_ADDR,
  input  logic [DATA_W-1:0] DM_WDATA,
  output logic              DM_GNT,
  output logic              DM_RVALID,
  output logic [DATA_W-1:0] DM_RDATA,
  output logic              DM_WDONE,
  output logic              MEM_EN,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_WDATA,
  input  logic [DATA_W-1:0] MEM_RDATA,
  output logic              BUSY
);

  localparam int SW = streak_w(MAX_DM_STREAK);
  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  state_t            state, state_nx;
  owner_t            own;
  logic              we;
  logic [SW-1:0]     streak;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] if_hold, dm_hold;
  logic              pick_vld;
  owner_t            pick_own;

  mem_arb_pick #(.MAX_DM_STREAK(MAX_DM_STREAK), .SW(SW)) u_pick (
    .if_req  (IF_REQ),
    .dm_req  (DM_REQ),
    .streak  (streak),
    .gnt_vld (pick_vld),
    .owner   (pick_own)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (pick_vld) state_nx = ISSUE;
      ISSUE: state_nx = (we || MEM_LAT == 1) ? RESP : WAIT;
      // cnt was loaded with MEM_LAT-1 in ISSUE; leave on the last WAIT cycle.
      WAIT:  if (cnt == CW'(1)) state_nx = RESP;
      RESP:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Request latch, streak, latency counter and held read data.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      own       <= OWN_IF;
      we        <= 1'b0;
      streak    <= '0;
      cnt       <= '0;
      MEM_ADDR  <= '0;
      MEM_WDATA <= '0;
      if_hold   <= '0;
      dm_hold   <= '0;
    end else begin
      case (state)
        IDLE: if (pick_vld) begin
          own <= pick_own;
          if (pick_own == OWN_DM) begin
            we        <= DM_WE;
            MEM_ADDR  <= DM_ADDR;
            MEM_WDATA <= DM_WDATA;
            // Only count DM grants that actually made fetch wait.
            if (IF_REQ && streak != SW'(MAX_DM_STREAK)) streak <= streak + SW'(1);
          end else begin
            we       <= 1'b0;
            MEM_ADDR <= IF_ADDR;
            streak   <= '0;
          end
        end
        ISSUE: cnt <= CW'(MEM_LAT - 1);
        WAIT:  cnt <= cnt - CW'(1);
        RESP: if (!we) begin
          if (own == OWN_IF) if_hold <= MEM_RDATA;
          else               dm_hold <= MEM_RDATA;
        end
        default: ;
      endcase
    end
  end

  assign BUSY      = (state != IDLE);
  assign MEM_EN    = (state == ISSUE);
  assign MEM_WE    = (state == ISSUE) && we;
  assign IF_GNT    = (state == ISSUE) && (own == OWN_IF);
  assign DM_GNT    = (state == ISSUE) && (own == OWN_DM);
  assign IF_RVALID = (state == RESP) && !we && (own == OWN_IF);
  assign DM_RVALID = (state == RESP) && !we && (own == OWN_DM);
  assign DM_WDONE  = (state == RESP) &&  we && (own == OWN_DM);
  // Memory data passes straight through in RESP, then the captured copy holds.
  assign IF_RDATA  = IF_RVALID ? MEM_RDATA : if_hold;
  assign DM_RDATA  = DM_RVALID ? MEM_RDATA : dm_hold;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: dut (MEM_LAT=1) and dut3 (MEM_LAT=3) sharing one memory image.
module tb_mem_port_arbiter;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;

  logic        IF_REQ = 0, IF_GNT, IF_RVALID;
  logic [31:0] IF_ADDR = 0;
  logic [63:0] IF_RDATA;
  logic        DM_REQ = 0, DM_WE = 0, DM_GNT, DM_RVALID, DM_WDONE;
  logic [31:0] DM_ADDR = 0;
  logic [63:0] DM_WDATA = 0, DM_RDATA;
  logic        MEM_EN, MEM_WE, BUSY;
  logic [31:0] MEM_ADDR;
  logic [63:0] MEM_WDATA, MEM_RDATA;

  logic        IF_REQ3 = 0, IF_GNT3, IF_RVALID3;
  logic [31:0] IF_ADDR3 = 0;
  logic [63:0] IF_RDATA3;
  logic        DM_REQ3 = 0, DM_WE3 = 0, DM_GNT3, DM_RVALID3, DM_WDONE3;
  logic [31:0] DM_ADDR3 = 0;
  logic [63:0] DM_WDATA3 = 0, DM_RDATA3;
  logic        MEM_EN3, MEM_WE3, BUSY3;
  logic [31:0] MEM_ADDR3;
  logic [63:0] MEM_WDATA3, MEM_RDATA3;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(64), .MEM_LAT(1), .MAX_DM_STREAK(4)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .IF_REQ(IF_REQ), .IF_ADDR(IF_ADDR), .IF_GNT(IF_GNT), .IF_RVALID(IF_RVALID), .IF_RDATA(IF_RDATA),
    .DM_REQ(DM_REQ), .DM_WE(DM_WE), .DM_ADDR(DM_ADDR), .DM_WDATA(DM_WDATA), .DM_GNT(DM_GNT),
    .DM_RVALID(DM_RVALID), .DM_RDATA(DM_RDATA), .DM_WDONE(DM_WDONE),
    .MEM_EN(MEM_EN), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
    .MEM_RDATA(MEM_RDATA), .BUSY(BUSY)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(64), .MEM_LAT(3), .MAX_DM_STREAK(4)) dut3 (
    .CLK(CLK), .RST_N(RST_N),
    .IF_REQ(IF_REQ3), .IF_ADDR(IF_ADDR3), .IF_GNT(IF_GNT3), .IF_RVALID(IF_RVALID3), .IF_RDATA(IF_RDATA3),
    .DM_REQ(DM_REQ3), .DM_WE(DM_WE3), .DM_ADDR(DM_ADDR3), .DM_WDATA(DM_WDATA3), .DM_GNT(DM_GNT3),
    .DM_RVALID(DM_RVALID3), .DM_RDATA(DM_RDATA3), .DM_WDONE(DM_WDONE3),
    .MEM_EN(MEM_EN3), .MEM_WE(MEM_WE3), .MEM_ADDR(MEM_ADDR3), .MEM_WDATA(MEM_WDATA3),
    .MEM_RDATA(MEM_RDATA3), .BUSY(BUSY3)
  );

  // Memory image: fixed pattern plus a write overlay fed by dut only.
  function automatic logic [63:0] init_val(input logic [7:0] a);
    return (a == 8'h10) ? 64'h13 : 64'h1000 + {56'd0, a};
  endfunction

  logic [63:0]  wmem [0:255];
  logic [255:0] wvld = '0;
  logic [7:0]   raddr = '0, raddr3 = '0;

  always @(posedge CLK) begin
    if (MEM_EN && MEM_WE) begin
      wmem[MEM_ADDR[7:0]] <= MEM_WDATA;
      wvld[MEM_ADDR[7:0]] <= 1'b1;
    end
    if (MEM_EN && !MEM_WE) raddr  <= MEM_ADDR[7:0];
    if (MEM_EN3 && !MEM_WE3) raddr3 <= MEM_ADDR3[7:0];
  end

  assign MEM_RDATA  = wvld[raddr]  ? wmem[raddr]  : init_val(raddr);
  assign MEM_RDATA3 = wvld[raddr3] ? wmem[raddr3] : init_val(raddr3);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    logic seen, stale;

    // Reset state
    #2;
    chk("rst_busy", BUSY, 0);
    chk("rst_mem_en", MEM_EN, 0);
    chk("rst_gnt", {IF_GNT, DM_GNT}, 0);
    chk("rst_rdata", IF_RDATA | DM_RDATA, 0);
    chk("rst_streak", dut.streak, 0);
    tick(); tick();
    RST_N = 1'b1;
    tick();

    // IF-only read, 0x10 -> 0x13
    IF_REQ = 1; IF_ADDR = 32'h10;
    tick();
    chk("if_gnt", IF_GNT, 1);
    chk("if_dm_gnt", DM_GNT, 0);
    chk("if_mem_en", MEM_EN, 1);
    chk("if_mem_we", MEM_WE, 0);
    chk("if_mem_addr", MEM_ADDR, 64'h10);
    chk("if_busy1", BUSY, 1);
    IF_REQ = 0;
    tick();
    chk("if_rvalid", IF_RVALID, 1);
    chk("if_rdata", IF_RDATA, 64'h13);
    chk("if_dm_rvalid", DM_RVALID, 0);
    chk("if_busy2", BUSY, 1);
    tick();
    chk("if_busy3", BUSY, 0);
    chk("if_rvalid_off", IF_RVALID, 0);
    chk("if_rdata_hold", IF_RDATA, 64'h13);

    // Contested: DM read 0x40 wins, IF follows
    IF_REQ = 1; DM_REQ = 1; DM_WE = 0; DM_ADDR = 32'h40;
    tick();
    chk("both_dm_gnt", DM_GNT, 1);
    chk("both_if_gnt", IF_GNT, 0);
    chk("both_streak1", dut.streak, 1);
    DM_REQ = 0;
    tick();
    chk("both_dm_rvalid", DM_RVALID, 1);
    chk("both_dm_rdata", DM_RDATA, 64'h1040);
    chk("both_if_rvalid", IF_RVALID, 0);
    tick();
    chk("both_idle", BUSY, 0);
    tick();
    chk("both_if_gnt2", IF_GNT, 1);
    chk("both_streak0", dut.streak, 0);
    IF_REQ = 0;
    tick(); tick();
    chk("both_idle2", BUSY, 0);

    // Streak limit: DM x4 then IF
    IF_REQ = 1; DM_REQ = 1; DM_WE = 0; DM_ADDR = 32'h40; IF_ADDR = 32'h10;
    for (int g = 0; g < 5; g++) begin
      seen = 0;
      for (int n = 0; n < 8 && !seen; n++) begin
        tick();
        if (IF_GNT || DM_GNT) seen = 1;
      end
      chk("streak_grant_seen", seen, 1);
      chk("streak_dm_gnt", DM_GNT, (g < 4));
      chk("streak_if_gnt", IF_GNT, (g == 4));
      if (g == 3) chk("streak_sat", dut.streak, 4);
      if (g == 4) begin
        chk("streak_clr", dut.streak, 0);
        IF_REQ = 0; DM_REQ = 0;
      end
    end
    seen = 0;
    for (int n = 0; n < 8 && !seen; n++) begin
      tick();
      if (!BUSY) seen = 1;
    end
    chk("streak_drain", seen, 1);

    // DM write then readback
    DM_REQ = 1; DM_WE = 1; DM_ADDR = 32'h80; DM_WDATA = 64'hDEADBEEF_CAFEF00D;
    tick();
    chk("wr_gnt", DM_GNT, 1);
    chk("wr_en_we", {MEM_EN, MEM_WE}, 2'b11);
    chk("wr_addr", MEM_ADDR, 64'h80);
    chk("wr_data", MEM_WDATA, 64'hDEADBEEF_CAFEF00D);
    DM_REQ = 0; DM_WE = 0;
    tick();
    chk("wr_wdone", DM_WDONE, 1);
    chk("wr_no_rvalid", {IF_RVALID, DM_RVALID}, 0);
    chk("wr_we_off", {MEM_EN, MEM_WE}, 0);
    tick();
    chk("wr_wdone_off", DM_WDONE, 0);
    DM_REQ = 1; DM_ADDR = 32'h80;
    tick();
    chk("rb_gnt", DM_GNT, 1);
    DM_REQ = 0;
    tick();
    chk("rb_rvalid", DM_RVALID, 1);
    chk("rb_rdata", DM_RDATA, 64'hDEADBEEF_CAFEF00D);
    tick();

    // MEM_LAT=3 DM read of 0x20
    DM_REQ3 = 1; DM_WE3 = 0; DM_ADDR3 = 32'h20;
    tick();
    chk("l3_gnt", DM_GNT3, 1);
    chk("l3_en", MEM_EN3, 1);
    DM_REQ3 = 0;
    tick();
    chk("l3_wait1", {MEM_EN3, DM_RVALID3, BUSY3}, 3'b001);
    tick();
    chk("l3_wait2", {MEM_EN3, DM_RVALID3, BUSY3}, 3'b001);
    tick();
    chk("l3_rvalid", DM_RVALID3, 1);
    chk("l3_rdata", DM_RDATA3, 64'h1020);
    tick();
    chk("l3_idle", BUSY3, 0);

    // Reset during WAIT
    IF_REQ3 = 1; IF_ADDR3 = 32'h30;
    tick();
    chk("rw_gnt", IF_GNT3, 1);
    IF_REQ3 = 0;
    tick();
    chk("rw_in_wait", {BUSY3, MEM_EN3}, 2'b10);
    #2 RST_N = 0;
    #1;
    chk("rw_busy", BUSY3, 0);
    chk("rw_mem_addr", MEM_ADDR3, 0);
    chk("rw_dm_rdata", DM_RDATA3, 0);
    chk("rw_if_rdata_dut1", IF_RDATA, 0);
    chk("rw_mem_wdata_dut1", MEM_WDATA, 0);
    tick();
    RST_N = 1;
    stale = 0;
    for (int n = 0; n < 5; n++) begin
      tick();
      stale = stale | IF_RVALID3 | IF_GNT3 | BUSY3;
    end
    chk("rw_no_stale", stale, 0);
    IF_REQ3 = 1; IF_ADDR3 = 32'h30;
    tick();
    chk("rw_new_gnt", IF_GNT3, 1);
    IF_REQ3 = 0;
    tick(); tick(); tick();
    chk("rw_new_rvalid", IF_RVALID3, 1);
    chk("rw_new_rdata", IF_RDATA3, 64'h1030);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
